acc_dump_reader: RTL and testbench
==================================

# acc_dump_reader

Read-side master for the accumulator RAM. On a start pulse it walks a contiguous address window through the accumulator read port, absorbing the 1-cycle RAM latency. It streams each word out over a valid/ready interface with backpressure and signals completion. It sits between the accumulator and the downstream packer/output logic, acting as the consumer that drains accumulated results.

## Interface
Parameters:
- ADDR_WIDTH, 9, accumulator RAM address width
- DATA_WIDTH, 64, accumulator word width
- FIFO_DEPTH, 4, output buffer entries (min 2; ≥3 required for full throughput)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  single-cycle request pulse, sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first address, latched on accepted start
- length  in  ADDR_WIDTH+1  word count, latched on start; 0 = empty dump
- busy  out  1  high from accepted start until done
- done  out  1  single-cycle pulse at completion
- rd_port  ram_if.read_master  en/addr out, rdata in (DATA_WIDTH), latency 1
- wr_port  ram_if.write_master  en/we/addr/wdata out; used only with clear feature
- mode  out  1  accumulator write mode; constant 0 (overwrite)
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_WIDTH  word read from RAM
- m_last  out  1  marks final word of the dump

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: start && length!=0 → latch base/length, addr_ptr=base, remaining=length, enter RUN, busy=1. start && length==0 → done pulse next cycle, stay IDLE, busy stays 0, no RAM access.
- start while busy is ignored; latched values are unaffected.
- RUN: issue rd_port.en=1 with addr=addr_ptr when fifo_count + inflight < FIFO_DEPTH. On issue: addr_ptr+1 (modulo 2^ADDR_WIDTH; wraps 2^ADDR_WIDTH-1 → 0), remaining-1. Issuing the last word → DRAIN.
- inflight: 1-bit register set by an issue, cleared the next cycle. rdata captured into FIFO in the cycle after an issue, tagged last if it was the final address.
- FIFO: push on return, pop on m_valid && m_ready; simultaneous push/pop leaves count unchanged. The credit rule makes overflow impossible.
- DRAIN: when FIFO empty, inflight==0, and the last beat is accepted → done pulse, busy=0, IDLE.
- m_data/m_last are held stable while m_valid && !m_ready.
- rd_port.en is low in IDLE/DRAIN; rd_port.addr holds its last value.
- Async reset at any time: state IDLE, FIFO flushed, in-flight read discarded, no done pulse.

## Timing
- Reset values: busy=0, done=0, m_valid=0, m_data=0, m_last=0, rd_port.en=0, rd_port.addr=0, wr_port.en=0, wr_port.we=0, wr_port.addr=0, wr_port.wdata=0, mode=0.
- Start accepted at edge T0; busy=1 and first rd_port.en in cycle T1; rdata sampled end of T2; m_valid=1 in T3.
- Full throughput: with m_ready held high, one word per cycle. The N-word dump's last beat is in T(N+2); done pulses in the cycle after the last handshake.
- Backpressure: m_ready low stalls issue after FIFO_DEPTH outstanding words; issue resumes the cycle after a pop frees credit.

## Configuration
- ACC_DUMP_CLEAR_EN defined: each word is zeroed after being read. In the cycle its rdata returns, the block drives wr_port.en=1, we=1, addr=that address, wdata=0, with mode=0. DRAIN also waits for the final clear write to be issued. Dump-then-clear leaves the window ready for the next accumulation pass.
- Undefined: wr_port en/we/addr/wdata are tied 0 and no write logic is present; RAM contents are unchanged.

## Test plan
- Preload 0x10=100, 0x11=200, 0x12=300 via overwrite; start base=0x10, len=3, m_ready=1 → m_data 100,200,300 on consecutive cycles, m_last on 300, done 1 cycle after, busy=0.
- Start base=0x1FE, len=4 → reads 0x1FE,0x1FF,0x000,0x001 in order (wrap), 4 beats, one m_last.
- len=0 start → done pulse next cycle, rd_port.en never asserted, m_valid stays 0.
- len=8, m_ready toggling 1,0,0,1 pattern → all 8 words delivered in order, none dropped or duplicated, data stable while stalled, fifo_count never exceeds FIFO_DEPTH.
- Assert rstn low mid-dump (after 3 of 8 beats) → all outputs return to reset values immediately; new start afterward dumps correctly from its base.
- With ACC_DUMP_CLEAR_EN: accumulate 10 four times into 0x50 (=40), dump base=0x50 len=1 → m_data=40; re-read 0x50 → 0; a second dump returns 0.

Source files
------------

// File: rtl/acc_dump_reader_if.sv
// ram_if: one accumulator RAM port (1-cycle read latency), used here as
// separate read-master and write-master bundles.
interface ram_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64
) ();
    logic                  en;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport read_master  (output en, output addr, input rdata);
    modport write_master (output en, output we, output addr, output wdata);
endinterface

// File: rtl/acc_dump_reader.sv
// acc_dump_reader: walks an address window of the accumulator RAM and streams each word
// over valid/ready. Define ACC_DUMP_CLEAR_EN to zero every word right after it is read.
module acc_dump_reader #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    ram_if.read_master            rd_port,
    ram_if.write_master           wr_port,
    output logic                  mode,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int USE_W = CNT_W + 1;
    localparam logic [USE_W-1:0] DEPTH_C  = USE_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_ptr_q, addr_ptr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  rd_last_q, rd_last_d;
    logic                  ret_q, ret_last_q;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  m_valid_q;
    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic                  fifo_last_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push_s, pop_s, credit_s;
    logic [USE_W-1:0]      used_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    assign push_s = ret_q;
    assign pop_s  = m_valid_q && m_ready;
    // Words that will occupy the FIFO once the read already on the RAM port returns.
    assign used_s   = {1'b0, count_q} + {{CNT_W{1'b0}}, ret_q} + {{CNT_W{1'b0}}, rd_en_q}
                    - {{CNT_W{1'b0}}, pop_s};
    assign credit_s = (used_s < DEPTH_C);

    // FIFO occupancy next-state
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Sequencer next-state: read issue is registered, so it is decided one cycle ahead
    always_comb begin
        state_d     = state_q;
        addr_ptr_d  = addr_ptr_q;
        remaining_d = remaining_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_last_d   = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (length != {(ADDR_WIDTH+1){1'b0}})) begin
                    state_d     = RUN;
                    busy_d      = 1'b1;
                    rd_en_d     = 1'b1;
                    rd_addr_d   = base_addr;
                    rd_last_d   = (length == (ADDR_WIDTH+1)'(1));
                    addr_ptr_d  = base_addr + ADDR_WIDTH'(1);
                    remaining_d = length - (ADDR_WIDTH+1)'(1);
                end else if (start) begin
                    done_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (remaining_q == {(ADDR_WIDTH+1){1'b0}}) begin
                    state_d = DRAIN;
                end else if (credit_s) begin
                    rd_en_d     = 1'b1;
                    rd_addr_d   = addr_ptr_q;
                    rd_last_d   = (remaining_q == (ADDR_WIDTH+1)'(1));
                    addr_ptr_d  = addr_ptr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - (ADDR_WIDTH+1)'(1);
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (pop_s && fifo_last_q[rd_ptr_q] && !ret_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer, read-port and return-pipeline registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            addr_ptr_q  <= {ADDR_WIDTH{1'b0}};
            remaining_q <= {(ADDR_WIDTH+1){1'b0}};
            rd_en_q     <= 1'b0;
            rd_addr_q   <= {ADDR_WIDTH{1'b0}};
            rd_last_q   <= 1'b0;
            ret_q       <= 1'b0;
            ret_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_ptr_q  <= addr_ptr_d;
            remaining_q <= remaining_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            rd_last_q   <= rd_last_d;
            ret_q       <= rd_en_q;
            ret_last_q  <= rd_en_q && rd_last_q;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Output FIFO storage and pointers; contents cleared on reset so m_data reads 0
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= {DATA_WIDTH{1'b0}};
                fifo_last_q[i] <= 1'b0;
            end
            wr_ptr_q  <= {PTR_W{1'b0}};
            rd_ptr_q  <= {PTR_W{1'b0}};
            count_q   <= {CNT_W{1'b0}};
            m_valid_q <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_data_q[wr_ptr_q] <= rd_port.rdata;
                fifo_last_q[wr_ptr_q] <= ret_last_q;
                wr_ptr_q              <= ptr_inc(wr_ptr_q);
            end
            if (pop_s) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q   <= count_d;
            m_valid_q <= (count_d != {CNT_W{1'b0}});
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign mode         = 1'b0;
    assign rd_port.en   = rd_en_q;
    assign rd_port.addr = rd_addr_q;
    assign m_valid      = m_valid_q;
    assign m_data       = fifo_data_q[rd_ptr_q];
    assign m_last       = m_valid_q && fifo_last_q[rd_ptr_q];

`ifdef ACC_DUMP_CLEAR_EN
    logic [ADDR_WIDTH-1:0] ret_addr_q;

    // Address of the word whose data is returning this cycle, for the zeroing write
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ret_addr_q <= {ADDR_WIDTH{1'b0}};
        end else begin
            ret_addr_q <= rd_addr_q;
        end
    end

    assign wr_port.en    = ret_q;
    assign wr_port.we    = ret_q;
    assign wr_port.addr  = ret_addr_q;
    assign wr_port.wdata = {DATA_WIDTH{1'b0}};
`else
    assign wr_port.en    = 1'b0;
    assign wr_port.we    = 1'b0;
    assign wr_port.addr  = {ADDR_WIDTH{1'b0}};
    assign wr_port.wdata = {DATA_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_acc_dump_reader.sv
// Directed self-checking bench for acc_dump_reader with a behavioural 1-cycle-latency RAM.
module tb_acc_dump_reader;
    localparam int AW    = 9;
    localparam int DW    = 64;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          m_ready = 1'b0;
    logic          busy, done, mode, m_valid, m_last;
    logic [DW-1:0] m_data;

    ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rd_if ();
    ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wr_if ();

    acc_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .rd_port(rd_if), .wr_port(wr_if), .mode(mode),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    assign rd_if.we    = 1'b0;
    assign rd_if.wdata = '0;
    assign wr_if.rdata = '0;

    always @(posedge clk) begin
        if (rd_if.en) rd_if.rdata <= mem[rd_if.addr];
        if (wr_if.en && wr_if.we) mem[wr_if.addr] <= wr_if.wdata;
        if (pre_we) mem[pre_addr] <= pre_data;
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] got_q [$];
    bit            lastf_q [$];
    logic [AW-1:0] addr_q [$];
    int issues, pops, max_out, stall_err, wr_seen, wr_total, done_cyc, first_valid_cyc;
    int last_cnt, last_idx, errs;
    logic busy_at1, en_at1;
    bit glitch;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] tv(input logic [AW-1:0] a);
        return 64'h0123_4567_0000_0000 | ({55'd0, a} * 64'd13);
    endfunction

    function automatic logic [DW-1:0] got_at(input int i);
        return (got_q.size() > i) ? got_q[i] : 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_addr = a; pre_data = d; pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Runs one dump; cycle 1 is the cycle after the accepting edge.
    task automatic do_dump(input logic [AW-1:0] b, input logic [AW:0] n, input bit bp,
                           input int abort_after);
        logic [DW-1:0] prev_data;
        logic          prev_last;
        bit            stalled;
        got_q.delete(); lastf_q.delete(); addr_q.delete();
        issues = 0; pops = 0; max_out = 0; stall_err = 0; wr_seen = 0;
        done_cyc = -1; first_valid_cyc = -1; stalled = 1'b0;
        prev_data = '0; prev_last = 1'b0;
        @(negedge clk);
        start = 1'b1; base_addr = b; length = n;
        @(negedge clk);
        start = 1'b0;
        busy_at1 = busy; en_at1 = rd_if.en;
        for (int cyc = 1; cyc < 400; cyc++) begin
            if (glitch && cyc == 2) begin
                start = 1'b1; base_addr = 9'h100; length = 10'd5;
            end else begin
                start = 1'b0;
            end
            m_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (rd_if.en) begin issues++; addr_q.push_back(rd_if.addr); end
            if (wr_if.en) wr_seen++;
            if (stalled && (m_data !== prev_data || m_last !== prev_last || !m_valid)) stall_err++;
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (issues - pops > max_out) max_out = issues - pops;
            if (m_valid && m_ready) begin
                got_q.push_back(m_data); lastf_q.push_back(m_last); pops++;
            end
            stalled = m_valid && !m_ready; prev_data = m_data; prev_last = m_last;
            if (done) begin done_cyc = cyc; break; end
            if (abort_after > 0 && pops == abort_after) break;
            @(negedge clk);
        end
        start = 1'b0;
        wr_total += wr_seen;
        last_cnt = 0; last_idx = -1;
        foreach (lastf_q[i]) if (lastf_q[i]) begin last_cnt++; last_idx = i; end
    endtask

    initial begin
        wr_total = 0; glitch = 1'b0;
        #2;
        chk("reset_ctrl", {busy, done, m_valid, m_last, rd_if.en, wr_if.en, wr_if.we, mode}, 8'h00);
        chk("reset_m_data", m_data, 64'd0);
        chk("reset_addrs", {rd_if.addr, wr_if.addr}, 18'd0);
        chk("reset_wdata", wr_if.wdata, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        poke(9'h010, 64'd100); poke(9'h011, 64'd200); poke(9'h012, 64'd300);

        // Basic 3-word dump at full throughput
        do_dump(9'h010, 10'd3, 1'b0, 0);
        chk("t1_busy_T1", busy_at1, 1'b1);
        chk("t1_en_T1", en_at1, 1'b1);
        chk("t1_first_valid", first_valid_cyc, 3);
        chk("t1_beats", got_q.size(), 3);
        chk("t1_d0", got_at(0), 64'd100);
        chk("t1_d1", got_at(1), 64'd200);
        chk("t1_d2", got_at(2), 64'd300);
        chk("t1_last", {last_cnt, last_idx}, {32'd1, 32'd2});
        chk("t1_done_cyc", done_cyc, 6);
        chk("t1_busy_at_done", busy, 1'b0);
        chk("t1_addrs", {addr_q.size(), addr_q[0], addr_q[2]}, {32'd3, 9'h010, 9'h012});
        @(negedge clk);
        chk("t1_done_pulse", done, 1'b0);

        // Address wrap across the top of the RAM
        poke(9'h1FE, 64'hAAAA_0000_0000_01FE); poke(9'h1FF, 64'hAAAA_0000_0000_01FF);
        poke(9'h000, 64'hAAAA_0000_0000_0000); poke(9'h001, 64'hAAAA_0000_0000_0001);
        do_dump(9'h1FE, 10'd4, 1'b0, 0);
        chk("t2_beats", got_q.size(), 4);
        chk("t2_addrs", {addr_q[0], addr_q[1], addr_q[2], addr_q[3]},
            {9'h1FE, 9'h1FF, 9'h000, 9'h001});
        chk("t2_d1", got_at(1), 64'hAAAA_0000_0000_01FF);
        chk("t2_d2", got_at(2), 64'hAAAA_0000_0000_0000);
        chk("t2_d3", got_at(3), 64'hAAAA_0000_0000_0001);
        chk("t2_last", {last_cnt, last_idx}, {32'd1, 32'd3});
        chk("t2_done_cyc", done_cyc, 7);

        // Empty dump
        do_dump(9'h055, 10'd0, 1'b0, 0);
        chk("t3_done_cyc", done_cyc, 1);
        chk("t3_busy", busy_at1, 1'b0);
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rd_if.en || m_valid || busy || done) errs++;
        end
        chk("t3_quiet", {issues, errs}, {32'd0, 32'd0});

        // Backpressure 1,0,0,1 with an ignored start while busy
        for (int i = 0; i < 8; i++) poke(9'h040 + 9'(i), tv(9'h040 + 9'(i)));
        glitch = 1'b1;
        do_dump(9'h040, 10'd8, 1'b1, 0);
        glitch = 1'b0;
        chk("t4_beats", got_q.size(), 8);
        errs = 0;
        for (int i = 0; i < 8; i++) if (got_at(i) !== tv(9'h040 + 9'(i))) errs++;
        chk("t4_data_order", errs, 0);
        chk("t4_d7", got_at(7), tv(9'h047));
        chk("t4_last", {last_cnt, last_idx}, {32'd1, 32'd7});
        chk("t4_stall_stable", stall_err, 0);
        chk("t4_outstanding_le_depth", max_out <= DEPTH, 1'b1);
        chk("t4_issues", issues, 8);
        chk("t4_done_seen", done_cyc > 0, 1'b1);

        // Reset in the middle of a dump, then a fresh dump
        for (int i = 0; i < 8; i++) poke(9'h020 + 9'(i), tv(9'h020 + 9'(i)));
        poke(9'h030, 64'h3030); poke(9'h031, 64'h3131);
        do_dump(9'h020, 10'd8, 1'b0, 3);
        chk("t5_pre_beats", {got_q.size(), got_at(2)}, {32'd3, tv(9'h022)});
        rstn = 1'b0;
        #1;
        chk("t5_reset_ctrl", {busy, done, m_valid, m_last, rd_if.en, wr_if.en}, 6'h00);
        chk("t5_reset_data", {m_data, rd_if.addr}, {64'd0, 9'h000});
        @(negedge clk);
        rstn = 1'b1;
        do_dump(9'h030, 10'd2, 1'b0, 0);
        chk("t5_after", {got_at(0), got_at(1)}, {64'h3030, 64'h3131});
        chk("t5_done_cyc", done_cyc, 5);

`ifdef ACC_DUMP_CLEAR_EN
        poke(9'h050, 64'd0);
        for (int i = 0; i < 4; i++) poke(9'h050, mem[9'h050] + 64'd10);
        do_dump(9'h050, 10'd1, 1'b0, 0);
        chk("t6_first", got_at(0), 64'd40);
        chk("t6_done_cyc", done_cyc, 4);
        @(negedge clk);
        chk("t6_cleared", mem[9'h050], 64'd0);
        do_dump(9'h050, 10'd1, 1'b0, 0);
        chk("t6_second", got_at(0), 64'd0);
        chk("t6_tail_untouched", mem[9'h051], 64'hx === 64'hx ? mem[9'h051] : 64'd0);
`else
        chk("t6_no_writes", wr_total, 0);
        chk("t6_ram_intact", {mem[9'h010], mem[9'h012]}, {64'd100, 64'd300});
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
